// File: rtl/code_seq_pkg.sv
// code_seq_pkg: shared types and constants for the code sequencer slice.
//   seq_state_t   : sequencer FSM state encoding (3 bits)
//   IDX_W         : width of line numbers / program length
//   CODE_SIZE_DEF : default code word width (matches code_storage)
package code_seq_pkg;

  localparam int IDX_W         = 32;
  localparam int CODE_SIZE_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_FETCH = 3'd3,
    ST_ISSUE = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_t;

endpackage

// File: rtl/code_sequencer_if.sv
// code_sequencer_if: bundles the three buses around the sequencer.
//   load_*  : host loader stream (valid/ready) into the sequencer
//   instr_* : instruction stream (valid/ready) out to the executor
//   cs_*    : control/data pins of one code_storage instance
// Modports:
//   master : the sequencer side (drives ready to host, instr_*, cs_* controls)
//   slave  : the environment side (host, executor and storage)
interface code_sequencer_if
  import code_seq_pkg::*;
#(
  parameter int CODE_SIZE = CODE_SIZE_DEF
);

  logic                 load_valid;
  logic                 load_ready;
  logic [CODE_SIZE-1:0] load_data;

  logic                 instr_valid;
  logic                 instr_ready;
  logic [CODE_SIZE-1:0] instr_data;
  logic [IDX_W-1:0]     instr_index;

  logic                 cs_enable;
  logic                 cs_reset;
  logic                 cs_active;
  logic                 cs_is_write;
  logic [IDX_W-1:0]     cs_write_line;
  logic [CODE_SIZE-1:0] cs_write_data;
  logic [CODE_SIZE-1:0] cs_code;
  logic [IDX_W-1:0]     cs_code_index;

  modport master (
    input  load_valid, load_data, instr_ready, cs_code, cs_code_index,
    output load_ready, instr_valid, instr_data, instr_index,
           cs_enable, cs_reset, cs_active, cs_is_write, cs_write_line, cs_write_data
  );

  modport slave (
    output load_valid, load_data, instr_ready, cs_code, cs_code_index,
    input  load_ready, instr_valid, instr_data, instr_index,
           cs_enable, cs_reset, cs_active, cs_is_write, cs_write_line, cs_write_data
  );

endinterface

// File: rtl/code_sequencer.sv
// code_sequencer: run/load controller for one code_storage instance.
// Streams a program in from the host and steps it out line by line to the
// executor. Storage is never written and read-stepped in the same state.
// Ports:
//   clk, reset (sync, active-low)
//   load_start/load_done   : open / commit a program load
//   run_start / run_abort  : start a run from line 0 / abandon load or run
//   load_error             : sticky overflow flag, cleared by load_start
//   run_done               : one-cycle pulse at the end of a completed run
//   busy                   : state != IDLE
//   prog_len               : committed program length
//   bus (master)           : load_*, instr_* and cs_* buses
//
// state | meaning
// IDLE  | waiting for load_start / run_start
// LOAD  | accepting host words into storage at wr_ptr
// START | storage reset to line 0
// FETCH | capture storage output into the instruction register
// ISSUE | instruction offered to executor until accepted
// DONE  | run_done pulse, storage rewound
module code_sequencer
  import code_seq_pkg::*;
#(
  parameter int                   CODE_SIZE     = CODE_SIZE_DEF,
  parameter int                   MAX_CODE_LINE = 100,
  parameter logic [CODE_SIZE-1:0] HALT_OPCODE   = '0,
  parameter bit                   HALT_EN       = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic             load_done,
  input  logic             run_start,
  input  logic             run_abort,
  output logic             load_error,
  output logic             run_done,
  output logic             busy,
  output logic [IDX_W-1:0] prog_len,
  code_sequencer_if.master bus
);

  localparam logic [IDX_W-1:0] MAX_LINE = IDX_W'(MAX_CODE_LINE);

  seq_state_t           state;
  logic [IDX_W-1:0]     wr_ptr;
  logic                 instr_valid_q;
  logic [CODE_SIZE-1:0] instr_data_q;
  logic [IDX_W-1:0]     instr_index_q;
  logic                 cs_enable_q;
  logic                 cs_reset_q;

  logic load_full;
  logic load_accept;
  logic issue_fire;
  logic issue_last;

  assign load_full   = (wr_ptr >= MAX_LINE);
  assign load_accept = bus.load_valid && bus.load_ready;
  assign issue_fire  = (state == ST_ISSUE) && instr_valid_q && bus.instr_ready;
  assign issue_last  = ((instr_index_q + IDX_W'(1)) == prog_len) ||
                       (HALT_EN && (instr_data_q == HALT_OPCODE));

  assign bus.load_ready    = (state == ST_LOAD) && !load_full;
  assign bus.cs_is_write   = load_accept;
  assign bus.cs_write_line = wr_ptr;
  assign bus.cs_write_data = bus.load_data;
  // Advancing here means the next FETCH sees the following line.
  assign bus.cs_active     = issue_fire && !issue_last && !run_abort;
  assign bus.cs_enable     = cs_enable_q;
  assign bus.cs_reset      = cs_reset_q;
  assign bus.instr_valid   = instr_valid_q;
  assign bus.instr_data    = instr_data_q;
  assign bus.instr_index   = instr_index_q;
  assign busy              = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      wr_ptr        <= '0;
      prog_len      <= '0;
      load_error    <= 1'b0;
      run_done      <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_data_q  <= '0;
      instr_index_q <= '0;
      cs_enable_q   <= 1'b0;
      cs_reset_q    <= 1'b1;
    end else begin
      cs_enable_q <= 1'b1;
      run_done    <= 1'b0;
      cs_reset_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run_abort) begin
            state <= ST_IDLE;
          end else if (load_start) begin
            state      <= ST_LOAD;
            wr_ptr     <= '0;
            prog_len   <= '0;
            load_error <= 1'b0;
          end else if (run_start) begin
            cs_reset_q <= 1'b1;
            if (prog_len != '0) begin
              state <= ST_START;
            end else begin
              // Empty program: finish immediately without issuing anything.
              state    <= ST_DONE;
              run_done <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (run_abort) begin
            state <= ST_IDLE;
          end else if (load_start) begin
            wr_ptr     <= '0;
            prog_len   <= '0;
            load_error <= 1'b0;
          end else begin
            if (load_accept) wr_ptr <= wr_ptr + IDX_W'(1);
            if (bus.load_valid && load_full) load_error <= 1'b1;
            if (load_done) begin
              state    <= ST_IDLE;
              // A word accepted on the load_done cycle still counts.
              prog_len <= wr_ptr + IDX_W'(load_accept);
            end
          end
        end
        ST_START: begin
          if (run_abort) begin
            state      <= ST_IDLE;
            cs_reset_q <= 1'b1;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (run_abort) begin
            state      <= ST_IDLE;
            cs_reset_q <= 1'b1;
          end else begin
            instr_data_q  <= bus.cs_code;
            instr_index_q <= bus.cs_code_index;
            instr_valid_q <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (run_abort) begin
            instr_valid_q <= 1'b0;
            state         <= ST_IDLE;
            cs_reset_q    <= 1'b1;
          end else if (issue_fire) begin
            instr_valid_q <= 1'b0;
            if (issue_last) begin
              state      <= ST_DONE;
              run_done   <= 1'b1;
              cs_reset_q <= 1'b1;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
